// File: rtl/float_normalizer_pipe.sv
// Two-stage float normaliser with valid/ready flow control.
// Stage 1 forms the magnitude and leading-zero count. Stage 2 shifts the mantissa, adjusts the exponent and sets the flags.
module float_normalizer_pipe #(
  parameter int MANT_W  = 25,
  parameter int EXP_W   = 8,
  parameter int TWOS_IN = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_sign,
  output logic              out_zero,
  output logic              out_uf,
  output logic              out_of,
  output logic              out_sticky
);

  localparam int LZ_W = $clog2(MANT_W);
  localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

  logic              s1_valid_reg;
  logic              s2_valid_reg;
  logic [MANT_W-1:0] s1_mag_reg;
  logic [EXP_W-1:0]  s1_exp_reg;
  logic              s1_sign_reg;
  logic [LZ_W-1:0]   s1_lz_reg;

  logic              s2_load;
  logic [MANT_W-1:0] mag_next;
  logic              sign_next;
  logic [LZ_W-1:0]   lz_next;

  // Stage 2 takes new data when it is empty or its result leaves this cycle.
  assign s2_load   = !s2_valid_reg || out_ready;
  assign in_ready  = rst_n && (!s1_valid_reg || s2_load);
  assign out_valid = s2_valid_reg;

  always_comb begin
    mag_next  = in_mant;
    sign_next = in_sign;
    if ((TWOS_IN != 0) && in_mant[MANT_W-1]) begin
      mag_next  = -in_mant;
      sign_next = ~in_sign;
    end
  end

  // Ascending scan, so the highest set bit below the carry position wins.
  always_comb begin
    lz_next = '0;
    for (int i = 0; i <= MANT_W - 2; i++) begin
      if (mag_next[i]) lz_next = LZ_W'(MANT_W - 2 - i);
    end
  end

  logic              carry;
  logic [EXP_W:0]    exp_inc;
  logic [EXP_W:0]    lz_ext;
  logic [MANT_W-1:0] mant_next;
  logic [EXP_W-1:0]  exp_next;
  logic              zero_next;
  logic              uf_next;
  logic              of_next;
  logic              sticky_next;

  assign carry   = s1_mag_reg[MANT_W-1];
  assign exp_inc = {1'b0, s1_exp_reg} + 1'b1;
  assign lz_ext  = (EXP_W + 1)'(s1_lz_reg);

  always_comb begin
    mant_next   = '0;
    exp_next    = '0;
    zero_next   = 1'b0;
    uf_next     = 1'b0;
    of_next     = 1'b0;
    sticky_next = 1'b0;
    if (s1_mag_reg == '0) begin
      zero_next = 1'b1;
    end else if (carry) begin
      if (exp_inc >= EXP_MAX) begin
        of_next  = 1'b1;
        exp_next = '1;
      end else begin
        mant_next   = s1_mag_reg >> 1;
        exp_next    = exp_inc[EXP_W-1:0];
        sticky_next = s1_mag_reg[0];
      end
    end else if ({1'b0, s1_exp_reg} <= lz_ext) begin
      // Denormals are not produced; the result flushes to zero.
      uf_next = 1'b1;
    end else begin
      mant_next = s1_mag_reg << s1_lz_reg;
      exp_next  = s1_exp_reg - lz_ext[EXP_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      s1_mag_reg  <= mag_next;
      s1_exp_reg  <= in_exp;
      s1_sign_reg <= sign_next;
      s1_lz_reg   <= lz_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      out_mant     <= '0;
      out_exp      <= '0;
      out_sign     <= 1'b0;
      out_zero     <= 1'b0;
      out_uf       <= 1'b0;
      out_of       <= 1'b0;
      out_sticky   <= 1'b0;
    end else begin
      if (in_ready) s1_valid_reg <= in_valid;
      if (s2_load) s2_valid_reg <= s1_valid_reg;
      if (s2_load && s1_valid_reg) begin
        out_mant   <= mant_next;
        out_exp    <= exp_next;
        out_sign   <= s1_sign_reg;
        out_zero   <= zero_next;
        out_uf     <= uf_next;
        out_of     <= of_next;
        out_sticky <= sticky_next;
      end
    end
  end

endmodule

// File: tb/tb_float_normalizer_pipe.sv
// Bench for float_normalizer_pipe: one unsigned and one two's-complement instance share a single input stream.
// Results are scored against an arithmetic reference model.
module tb_float_normalizer_pipe;

  localparam int MW = 25;
  localparam int EW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sign = 1'b0;
  logic          out_ready = 1'b0;
  logic [MW-1:0] in_mant = '0;
  logic [EW-1:0] in_exp = '0;

  logic          in_ready0, in_ready1, out_valid0, out_valid1;
  logic [MW-1:0] mant0, mant1;
  logic [EW-1:0] exp0, exp1;
  logic          sign0, sign1, zero0, zero1, uf0, uf1, of0, of1, st0, st1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  float_normalizer_pipe #(.MANT_W(MW), .EXP_W(EW), .TWOS_IN(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid0), .out_ready(out_ready),
    .out_mant(mant0), .out_exp(exp0), .out_sign(sign0),
    .out_zero(zero0), .out_uf(uf0), .out_of(of0), .out_sticky(st0)
  );

  float_normalizer_pipe #(.MANT_W(MW), .EXP_W(EW), .TWOS_IN(1)) u_dut_tc (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_mant(in_mant), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_mant(mant1), .out_exp(exp1), .out_sign(sign1),
    .out_zero(zero1), .out_uf(uf1), .out_of(of1), .out_sticky(st1)
  );

  // Packed result layout: {mant, exp, sign, zero, uf, of, sticky}
  function automatic logic [37:0] pk(input logic [MW-1:0] m, input logic [EW-1:0] e,
                                     input logic s, input logic z, input logic u,
                                     input logic o, input logic st);
    return {m, e, s, z, u, o, st};
  endfunction

  function automatic logic [37:0] ref_model(input logic [MW-1:0] m, input logic [EW-1:0] e,
                                            input logic s, input bit twos);
    longint mag;
    int     ei, lz;
    logic   sg, z, u, o, st;
    logic [MW-1:0] rm;
    logic [EW-1:0] re;
    mag = longint'(m);
    ei  = int'(e);
    sg  = s;
    rm  = '0; re = '0; z = 0; u = 0; o = 0; st = 0;
    if (twos && mag >= 2**(MW-1)) begin
      mag = longint'(2**MW) - mag;
      sg  = ~s;
    end
    if (mag == 0) begin
      z = 1;
    end else if (mag >= 2**(MW-1)) begin
      if (ei + 1 >= 2**EW - 1) begin
        o  = 1;
        re = '1;
      end else begin
        rm = MW'(mag / 2);
        re = EW'(ei + 1);
        st = (mag % 2) != 0;
      end
    end else begin
      lz = 0;
      while (mag < 2**(MW-2)) begin
        mag = mag * 2;
        lz++;
      end
      if (ei <= lz) u = 1;
      else begin
        rm = MW'(mag);
        re = EW'(ei - lz);
      end
    end
    return pk(rm, re, sg, z, u, o, st);
  endfunction

  logic [37:0] q0[$];
  logic [37:0] q1[$];
  int          qt[$];
  bit          took_in, took_out;
  logic        rdy_s, rdy1_s, ov0_s, ov1_s;
  logic [37:0] obs0, obs1;
  int          tidx = 0;
  int          tcount = 0;

  // One clock cycle: sample outputs at the falling edge, record accepted beats, return 1ns after the rising edge.
  task automatic tick();
    @(negedge clk);
    rdy_s    = in_ready0;
    rdy1_s   = in_ready1;
    ov0_s    = out_valid0;
    ov1_s    = out_valid1;
    took_in  = in_valid && in_ready0 && rst_n;
    took_out = out_valid0 && out_ready && rst_n;
    obs0     = pk(mant0, exp0, sign0, zero0, uf0, of0, st0);
    obs1     = pk(mant1, exp1, sign1, zero1, uf1, of1, st1);
    tidx     = tcount;
    if (took_in) begin
      q0.push_back(ref_model(in_mant, in_exp, in_sign, 1'b0));
      q1.push_back(ref_model(in_mant, in_exp, in_sign, 1'b1));
      qt.push_back(tcount);
    end
    tcount++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beat();
    in_mant = MW'($urandom) >> $urandom_range(0, MW);
    in_sign = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       in_exp = EW'($urandom_range(0, 30));
      1:       in_exp = EW'($urandom_range(250, 255));
      default: in_exp = EW'($urandom_range(0, 255));
    endcase
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; out_ready = 1;
    tick();
    tick();
    checks++; if (ov0_s !== 1'b0 || ov1_s !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b/%b want 0", ov0_s, ov1_s); end
    checks++; if (rdy_s !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", rdy_s); end
    checks++; if (obs0 !== 38'h0) begin errors++; $display("FAIL reset_outputs0 got %h want 0", obs0); end
    checks++; if (obs1 !== 38'h0) begin errors++; $display("FAIL reset_outputs1 got %h want 0", obs1); end
    rst_n = 1;
    tick();
    checks++; if (rdy_s !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b want 1", rdy_s); end
  endtask

  task automatic test_directed();
    logic [MW-1:0] tm[7];
    logic [EW-1:0] te[7];
    logic          ts[7];
    logic [37:0]   c0[7];
    logic [37:0]   c1[7];
    logic [37:0]   e0, e1;
    int si, ri, lat, budget;
    tm[0] = 25'h0800000; te[0] = 8'd100; ts[0] = 0;
    tm[1] = 25'h0000001; te[1] = 8'd100; ts[1] = 0;
    tm[2] = 25'h0000100; te[2] = 8'd15;  ts[2] = 0;
    tm[3] = 25'h1000001; te[3] = 8'd100; ts[3] = 0;
    tm[4] = 25'h1000001; te[4] = 8'd254; ts[4] = 0;
    tm[5] = 25'h0000000; te[5] = 8'd77;  ts[5] = 1;
    tm[6] = 25'h1FFFFFF; te[6] = 8'd50;  ts[6] = 0;
    c0[0] = pk(25'h0800000, 8'd100, 0, 0, 0, 0, 0); c1[0] = c0[0];
    c0[1] = pk(25'h0800000, 8'd77,  0, 0, 0, 0, 0); c1[1] = c0[1];
    c0[2] = pk(25'h0,       8'd0,   0, 0, 1, 0, 0); c1[2] = c0[2];
    c0[3] = pk(25'h0800000, 8'd101, 0, 0, 0, 0, 1); c1[3] = pk(25'h0FFFFFF, 8'd100, 1, 0, 0, 0, 0);
    c0[4] = pk(25'h0,       8'hFF,  0, 0, 0, 1, 0); c1[4] = pk(25'h0FFFFFF, 8'd254, 1, 0, 0, 0, 0);
    c0[5] = pk(25'h0,       8'd0,   1, 1, 0, 0, 0); c1[5] = c0[5];
    c0[6] = pk(25'h0FFFFFF, 8'd51,  0, 0, 0, 0, 1); c1[6] = pk(25'h0800000, 8'd27, 1, 0, 0, 0, 0);
    si = 0; ri = 0; budget = 0;
    out_ready = 1;
    while (ri < 7 && budget < 50) begin
      in_valid = (si < 7);
      if (si < 7) begin in_mant = tm[si]; in_exp = te[si]; in_sign = ts[si]; end
      tick();
      budget++;
      if (took_in) si++;
      if (took_out) begin
        if (q0.size() == 0) begin
          checks++; errors++; $display("FAIL directed_unexpected_output got %h", obs0);
        end else begin
          e0 = q0.pop_front(); e1 = q1.pop_front(); lat = tidx - qt.pop_front();
          checks++; if (obs0 !== c0[ri]) begin errors++; $display("FAIL directed_const0[%0d] got %h want %h", ri, obs0, c0[ri]); end
          checks++; if (obs1 !== c1[ri]) begin errors++; $display("FAIL directed_const1[%0d] got %h want %h", ri, obs1, c1[ri]); end
          checks++; if (obs0 !== e0 || obs1 !== e1) begin errors++; $display("FAIL directed_model[%0d] got %h/%h want %h/%h", ri, obs0, obs1, e0, e1); end
          checks++; if (lat != 2) begin errors++; $display("FAIL directed_latency[%0d] got %0d want 2", ri, lat); end
          $display("directed beat %0d: mant0=%h exp0=%0d mant1=%h exp1=%0d", ri, mant0, exp0, mant1, exp1);
          ri++;
        end
      end
    end
    in_valid = 0;
    checks++; if (ri != 7) begin errors++; $display("FAIL directed_count got %0d want 7", ri); end
  endtask

  task automatic test_random();
    logic [37:0] e0, e1, prev0, prev1;
    bit prev_stall;
    int sent, got, budget;
    sent = 0; got = 0; budget = 0; prev_stall = 0; prev0 = '0; prev1 = '0;
    while ((sent < 200 || got < sent) && budget < 3000) begin
      in_valid  = (sent < 200) && ($urandom_range(0, 9) < 7);
      rand_beat();
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
      budget++;
      if (took_in) sent++;
      checks++; if (rdy1_s !== rdy_s || ov1_s !== ov0_s) begin errors++; $display("FAIL random_handshake_match got %b%b want %b%b", rdy1_s, ov1_s, rdy_s, ov0_s); end
      if (prev_stall) begin
        checks++;
        if (ov0_s !== 1'b1 || obs0 !== prev0 || obs1 !== prev1) begin
          errors++; $display("FAIL random_hold got %b %h want 1 %h", ov0_s, obs0, prev0);
        end
      end
      prev_stall = ov0_s && !out_ready;
      prev0 = obs0; prev1 = obs1;
      if (took_out) begin
        if (q0.size() == 0) begin
          checks++; errors++; $display("FAIL random_unexpected_output got %h", obs0);
        end else begin
          e0 = q0.pop_front(); e1 = q1.pop_front(); void'(qt.pop_front());
          checks++; if (obs0 !== e0) begin errors++; $display("FAIL random_result0[%0d] got %h want %h", got, obs0, e0); end
          checks++; if (obs1 !== e1) begin errors++; $display("FAIL random_result1[%0d] got %h want %h", got, obs1, e1); end
          got++;
        end
      end
    end
    in_valid = 0;
    $display("random stream: %0d beats sent, %0d received", sent, got);
    checks++; if (got != 200) begin errors++; $display("FAIL random_count got %0d want 200", got); end
  endtask

  task automatic test_back_to_back();
    logic [37:0] e0, e1, prev0, prev1;
    bit prev_stall, seen_low;
    int si, got;
    si = 0; got = 0; prev_stall = 0; seen_low = 0; prev0 = '0; prev1 = '0;
    for (int k = 0; k < 40 && got < 5; k++) begin
      out_ready = (k >= 4);
      in_valid  = (si < 5);
      rand_beat();
      tick();
      if (took_in) si++;
      if (!rdy_s && !seen_low) begin
        seen_low = 1;
        checks++; if (si != 2) begin errors++; $display("FAIL b2b_ready_fall accepted %0d want 2", si); end
      end
      if (prev_stall) begin
        checks++;
        if (ov0_s !== 1'b1 || obs0 !== prev0 || obs1 !== prev1) begin
          errors++; $display("FAIL b2b_hold got %b %h want 1 %h", ov0_s, obs0, prev0);
        end
      end
      prev_stall = ov0_s && !out_ready;
      prev0 = obs0; prev1 = obs1;
      if (took_out) begin
        if (q0.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_unexpected_output got %h", obs0);
        end else begin
          e0 = q0.pop_front(); e1 = q1.pop_front(); void'(qt.pop_front());
          checks++; if (obs0 !== e0 || obs1 !== e1) begin errors++; $display("FAIL b2b_result[%0d] got %h/%h want %h/%h", got, obs0, obs1, e0, e1); end
          $display("b2b beat %0d: mant0=%h exp0=%0d", got, mant0, exp0);
          got++;
        end
      end
    end
    in_valid = 0;
    checks++; if (!seen_low || got != 5) begin errors++; $display("FAIL b2b_complete got ready_low=%0d beats=%0d want 1 5", seen_low, got); end
  endtask

  task automatic test_reset_midflight();
    logic [37:0] e0, e1;
    int lat;
    bit done;
    out_ready = 0; in_valid = 1;
    rand_beat(); tick();
    rand_beat(); tick();
    in_valid = 0; rst_n = 0;
    tick();
    q0.delete(); q1.delete(); qt.delete();
    rst_n = 1; out_ready = 1;
    tick();
    checks++; if (ov0_s !== 1'b0 || ov1_s !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got %b/%b want 0", ov0_s, ov1_s); end
    checks++; if (rdy_s !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got %b want 1", rdy_s); end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (ov0_s !== 1'b0) begin errors++; $display("FAIL midreset_ghost_beat cycle %0d got %b want 0", k, ov0_s); end
    end
    in_valid = 1; in_mant = 25'h0001234; in_exp = 8'd90; in_sign = 1;
    tick();
    in_valid = 0;
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      tick();
      if (took_out) begin
        done = 1;
        if (q0.size() == 0) begin
          checks++; errors++; $display("FAIL midreset_unexpected_output got %h", obs0);
        end else begin
          e0 = q0.pop_front(); e1 = q1.pop_front(); lat = tidx - qt.pop_front();
          checks++; if (obs0 !== e0 || obs1 !== e1) begin errors++; $display("FAIL midreset_result got %h/%h want %h/%h", obs0, obs1, e0, e1); end
          checks++; if (lat != 2) begin errors++; $display("FAIL midreset_latency got %0d want 2", lat); end
          $display("post-reset beat: mant0=%h exp0=%0d latency=%0d", mant0, exp0, lat);
        end
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL midreset_timeout got no output want 1 beat"); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_normalizer_pipe.md
FLOAT_NORMALIZER_PIPE -- requirements
Module: float_normalizer_pipe

Interface
REQ-001 SHALL have parameter MANT_W, default 25, meaning mantissa width: bit MANT_W-1 is the carry bit and bit MANT_W-2 is the hidden-one position.
REQ-002 SHALL have parameter EXP_W, default 8, meaning biased exponent width.
REQ-003 SHALL have parameter TWOS_IN, default 0, meaning: 1 = in_mant is two's complement signed, 0 = in_mant is unsigned magnitude.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: input beat present.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts a beat this cycle.
REQ-008 SHALL have ports in_mant (input, MANT_W), in_exp (input, EXP_W) and in_sign (input, 1): the unnormalised operand.
REQ-009 SHALL have port out_valid, output, 1 bit: result present.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-011 SHALL have ports out_mant (output, MANT_W), out_exp (output, EXP_W) and out_sign (output, 1): the normalised result.
REQ-012 SHALL have flag outputs, 1 bit each: out_zero, out_uf (underflow), out_of (overflow), out_sticky (LSB dropped on right shift).

Function
REQ-013 SHALL be a 2-stage pipeline: S1 registers magnitude, sign and leading-zero count (lz); S2 registers the shift, exponent and flags; latency is 2 cycles under no backpressure.
REQ-014 SHALL transfer a beat when valid and ready are both high; a stage loads when it is empty or its contents move forward the same cycle.
REQ-015 SHALL drive in_ready = !S1_valid || (S1 advancing); full throughput is 1 beat/cycle while out_ready=1.
REQ-016 SHALL hold out_* stable while out_valid=1 and out_ready=0, and SHALL neither drop, duplicate nor reorder beats.
REQ-017 SHALL, when TWOS_IN=1 and in_mant[MANT_W-1]=1, use the two's-complement negation of in_mant as the magnitude and set out_sign = ~in_sign; otherwise magnitude = in_mant and out_sign = in_sign.
REQ-018 SHALL compute lz as the count of zeros from bit MANT_W-2 downward to the first 1 (range 0..MANT_W-2).
REQ-019 SHALL handle carry (magnitude bit MANT_W-1 = 1): out_mant = magnitude >> 1, out_exp = in_exp + 1, out_sticky = magnitude[0].
REQ-020 SHALL, on a carry with in_exp+1 >= 2^EXP_W-1, output out_of=1, out_exp = all ones, out_mant = 0.
REQ-021 SHALL handle no carry with nonzero magnitude: out_mant = magnitude << lz, out_exp = in_exp - lz, out_sticky = 0.
REQ-022 SHALL, in the no-carry case with in_exp <= lz, flush to zero: out_uf=1, out_exp=0, out_mant=0. Denormals are not supported.
REQ-023 SHALL treat magnitude = 0 as zero: out_zero=1, out_exp=0, out_mant=0, out_uf=0.
REQ-024 SHALL keep the flags mutually exclusive; every normalised nonzero result has bit MANT_W-1 = 0 and bit MANT_W-2 = 1.

Reset
REQ-025 SHALL, while rst_n=0 at a clock edge, clear both stage valids; out_valid=0, in_ready=0, and out_mant, out_exp, out_sign and all flags equal 0.
REQ-026 SHALL discard in-flight beats on reset mid-operation; in_ready returns to 1 on the first cycle after rst_n=1.

Verification (MANT_W=25, EXP_W=8)
REQ-027 SHALL pass: mant 0x0800000, exp 100, TWOS_IN=0 -> 2 cycles later mant 0x0800000, exp 100, all flags 0.
REQ-028 SHALL pass: mant 0x0000001, exp 100 -> mant 0x0800000, exp 77. Mant 0x0000100, exp 15 -> out_uf=1, mant 0, exp 0.
REQ-029 SHALL pass: mant 0x1000001, exp 100 -> mant 0x0800000, exp 101, sticky 1. Same mant with exp 254 -> out_of=1, exp 0xFF, mant 0.
REQ-030 SHALL pass: mant 0 -> out_zero=1. TWOS_IN=1, mant 0x1FFFFFF, exp 50, sign 0 -> mant 0x0800000, exp 27, sign 1.
REQ-031 SHALL pass: 5 back-to-back beats with out_ready=0 for 4 cycles -> in_ready falls after 2 accepted beats; all 5 results emerge in order and held stable.
REQ-032 SHALL pass: rst_n=0 for 1 cycle with 2 beats in flight -> neither beat emerges; out_valid=0; next beat has 2-cycle latency.
